// File: rtl/ram_fifo_ctrl_pkg.sv
// ============================================================================
//  Module      : ram_fifo_ctrl_pkg
//  Description : Shared widths, state encodings and helper for ram_fifo_ctrl.
//                Optional feature macro: FIFO_ERR_EN (adds the ERROR state).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_fifo_ctrl_pkg;

    localparam int c_DATA_W = 10;
    localparam int c_ADDR_W = 3;
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_DEPTH  = 1 << c_ADDR_W;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ACTIVE = 4'd3
`ifdef FIFO_ERR_EN
        , ST_ERROR = 4'd4
`endif
    } state_t;

    // Simultaneous push and pop leave the occupancy unchanged.
    function automatic logic [c_CNT_W-1:0] f_count_next(
        input logic [c_CNT_W-1:0] cnt,
        input logic               inc,
        input logic               dec
    );
        logic [c_CNT_W-1:0] res;
        res = cnt;
        if (inc && !dec)
            res = cnt + 1'b1;
        else if (dec && !inc)
            res = cnt - 1'b1;
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_fifo_ctrl_if.sv
// ============================================================================
//  Module      : ram_fifo_ctrl_if
//  Description : User-side and RAM-side signals of the RAM FIFO controller.
//                Optional feature macro: FIFO_ERR_EN (adds the error flag).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_fifo_ctrl_if;
    import ram_fifo_ctrl_pkg::*;

    logic                init;
    logic [c_ADDR_W-1:0] cfg_alm_full;
    logic [c_ADDR_W-1:0] cfg_alm_empty;
    logic                push;
    logic [c_DATA_W-1:0] data_in;
    logic                pop;
    logic [c_DATA_W-1:0] data_out;
    logic                valid_out;
    logic                full;
    logic                empty;
    logic                almost_full;
    logic                almost_empty;
    logic [c_CNT_W-1:0]  fifo_count;
    logic [3:0]          state;
    logic [c_DATA_W-1:0] data_a;
    logic [c_ADDR_W-1:0] addr_wa;
    logic                we_a;
    logic [c_ADDR_W-1:0] addr_ra;
    logic                re_a;
    logic [c_DATA_W-1:0] q_a;
`ifdef FIFO_ERR_EN
    logic                error;
`endif

    modport slave (
        input  init, cfg_alm_full, cfg_alm_empty, push, data_in, pop, q_a,
`ifdef FIFO_ERR_EN
        output error,
`endif
        output data_out, valid_out, full, empty, almost_full, almost_empty,
        output fifo_count, state, data_a, addr_wa, we_a, addr_ra, re_a
    );

    modport master (
        output init, cfg_alm_full, cfg_alm_empty, push, data_in, pop, q_a,
`ifdef FIFO_ERR_EN
        input  error,
`endif
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
        input  fifo_count, state, data_a, addr_wa, we_a, addr_ra, re_a
    );

endinterface

`default_nettype wire

// File: rtl/ram_fifo_ctrl_fifo_ptr.sv
// ============================================================================
//  Module      : fifo_ptr
//  Description : Wrapping address counter with increment enable, sync reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ptr #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    output logic [WIDTH-1:0]      o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    // Natural overflow gives the wrap from DEPTH-1 back to 0.
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (i_inc)
            r_ptr <= r_ptr + 1'b1;
    end

    assign o_ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : Runs an 8x10 dual-port RAM as a circular FIFO with
//                occupancy, full/empty and programmable almost flags.
//                Optional feature macro: FIFO_ERR_EN (sticky error + ERROR).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    ram_fifo_ctrl_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_ADDR_W-1:0] w_wr_ptr;
    logic [c_ADDR_W-1:0] w_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_next;
    logic [c_ADDR_W-1:0] r_thr_af;
    logic [c_ADDR_W-1:0] r_thr_ae;
    logic [c_ADDR_W-1:0] w_thr_af_next;
    logic [c_ADDR_W-1:0] w_thr_ae_next;
    logic                r_full;
    logic                r_empty;
    logic                r_alm_full;
    logic                r_alm_empty;
    logic                r_valid;
    logic                w_op_en;
    logic                w_is_full;
    logic                w_is_empty;
    logic                w_push_ok;
    logic                w_pop_ok;

    // Strobes are gated by reset so nothing reaches the RAM on the reset edge.
    assign w_op_en    = !reset && (r_state == ST_IDLE || r_state == ST_ACTIVE);
    assign w_is_full  = (r_count == c_CNT_W'(c_DEPTH));
    assign w_is_empty = (r_count == '0);
    assign w_push_ok  = w_op_en && bus.push && !w_is_full;
    assign w_pop_ok   = w_op_en && bus.pop  && !w_is_empty;

    assign w_count_next = f_count_next(r_count, w_push_ok, w_pop_ok);

`ifdef FIFO_ERR_EN
    logic w_reject;
    logic r_error;
    assign w_reject = w_op_en && ((bus.push && w_is_full) || (bus.pop && w_is_empty));
`endif

    always_comb begin
        w_thr_af_next = r_thr_af;
        w_thr_ae_next = r_thr_ae;
        if (r_state == ST_INIT) begin
            w_thr_af_next = bus.cfg_alm_full;
            w_thr_ae_next = bus.cfg_alm_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_RESET;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RESET:  w_state_next = ST_INIT;
            ST_INIT:   if (!bus.init) w_state_next = ST_IDLE;
            ST_IDLE, ST_ACTIVE: begin
                w_state_next = (w_count_next == '0) ? ST_IDLE : ST_ACTIVE;
`ifdef FIFO_ERR_EN
                if (w_reject)
                    w_state_next = ST_ERROR;
`endif
            end
`ifdef FIFO_ERR_EN
            ST_ERROR:  w_state_next = ST_ERROR;
`endif
            default:   w_state_next = ST_RESET;
        endcase
    end

    // Flags hold their reset values while in RESET, then track the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_thr_af    <= '0;
            r_thr_ae    <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_alm_full  <= 1'b0;
            r_alm_empty <= 1'b1;
            r_valid     <= 1'b0;
        end else begin
            r_count  <= w_count_next;
            r_thr_af <= w_thr_af_next;
            r_thr_ae <= w_thr_ae_next;
            r_valid  <= w_pop_ok;
            if (r_state != ST_RESET) begin
                r_full      <= (w_count_next == c_CNT_W'(c_DEPTH));
                r_empty     <= (w_count_next == '0);
                r_alm_full  <= (w_count_next >= {1'b0, w_thr_af_next});
                r_alm_empty <= (w_count_next <= {1'b0, w_thr_ae_next});
            end
        end
    end

`ifdef FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_error <= 1'b0;
        else if (w_reject)
            r_error <= 1'b1;
    end

    assign bus.error = r_error;
`endif

    fifo_ptr #(.WIDTH(c_ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (reset),
        .i_inc (w_push_ok),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.WIDTH(c_ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (reset),
        .i_inc (w_pop_ok),
        .o_ptr (w_rd_ptr)
    );

    assign bus.data_a       = bus.data_in;
    assign bus.addr_wa      = w_wr_ptr;
    assign bus.we_a         = w_push_ok;
    assign bus.addr_ra      = w_rd_ptr;
    assign bus.re_a         = w_pop_ok;
    assign bus.data_out     = bus.q_a;
    assign bus.valid_out    = r_valid;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_alm_full;
    assign bus.almost_empty = r_alm_empty;
    assign bus.fifo_count   = r_count;
    assign bus.state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
// ============================================================================
//  Module      : tb_ram_fifo_ctrl
//  Description : Self-checking bench for ram_fifo_ctrl with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_fifo_ctrl;
    import ram_fifo_ctrl_pkg::*;

    localparam int THR_AF = 6;
    localparam int THR_AE = 1;

    typedef struct {
        bit push;
        bit pop;
        bit exp_we;
        bit exp_re;
        int exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_fifo_ctrl_if bus();

    ram_fifo_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural stand-in for the RAM: registered read, one-cycle latency.
    logic [c_DATA_W-1:0] mem [c_DEPTH];
    always @(posedge clk) begin
        if (bus.we_a) mem[bus.addr_wa] <= bus.data_a;
        if (bus.re_a) bus.q_a <= mem[bus.addr_ra];
    end

    vec_t                tbl[$];
    logic [c_DATA_W-1:0] model_q[$];
    logic [c_DATA_W-1:0] exp_q[$];
    logic [c_DATA_W-1:0] data_ctr;
    int                  n_cmp = 0;
    int                  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic check_flags(input int cnt, input logic [3:0] st);
        chk("fifo_count",   bus.fifo_count,   cnt);
        chk("full",         bus.full,         cnt == c_DEPTH);
        chk("empty",        bus.empty,        cnt == 0);
        chk("almost_full",  bus.almost_full,  cnt >= THR_AF);
        chk("almost_empty", bus.almost_empty, cnt <= THR_AE);
        chk("state",        bus.state,        st);
    endtask

    task automatic add(input bit pu, input bit po, input bit we, input bit re, input int cnt);
        vec_t v;
        v.push = pu; v.pop = po; v.exp_we = we; v.exp_re = re; v.exp_cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v, input logic [c_DATA_W-1:0] d);
        logic [c_DATA_W-1:0] exp_d;
        bus.push    = v.push;
        bus.pop     = v.pop;
        bus.data_in = d;
        @(negedge clk);
        chk("we_a", bus.we_a, v.exp_we);
        chk("re_a", bus.re_a, v.exp_re);
        if (v.exp_we) chk("data_a", bus.data_a, d);
        if (v.exp_re) begin
            if (model_q.size() == 0) fail("model_underflow");
            else exp_q.push_back(model_q.pop_front());
        end
        if (v.exp_we) model_q.push_back(d);
        @(posedge clk); #1;
        check_flags(v.exp_cnt, (v.exp_cnt > 0) ? ST_ACTIVE : ST_IDLE);
        chk("valid_out", bus.valid_out, v.exp_re);
        if (bus.valid_out) begin
            if (exp_q.size() == 0) fail("valid_out_unexpected");
            else begin
                exp_d = exp_q.pop_front();
                chk("data_out", bus.data_out, exp_d);
            end
        end
    endtask

    task automatic do_reset_init();
        reset = 1'b1;
        bus.init = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
        bus.cfg_alm_full = '0; bus.cfg_alm_empty = '0;
        repeat (2) @(posedge clk);
        #1;
        check_flags(0, ST_RESET);
        chk("rst_valid_out", bus.valid_out, 1'b0);
        chk("rst_we_a", bus.we_a, 1'b0);
        chk("rst_re_a", bus.re_a, 1'b0);
`ifdef FIFO_ERR_EN
        chk("rst_error", bus.error, 1'b0);
`endif
        reset = 1'b0;
        bus.init = 1'b1;
        bus.cfg_alm_full = 3'(THR_AF);
        bus.cfg_alm_empty = 3'(THR_AE);
        @(posedge clk); #1;
        chk("state_init", bus.state, ST_INIT);
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 10'h155;
        @(negedge clk);
        chk("init_we_a", bus.we_a, 1'b0);
        chk("init_re_a", bus.re_a, 1'b0);
        @(posedge clk); #1;
        chk("state_init_hold", bus.state, ST_INIT);
        bus.push = 1'b0; bus.pop = 1'b0; bus.init = 1'b0;
        @(posedge clk); #1;
        check_flags(0, ST_IDLE);
        // Thresholds must stay latched once INIT is left.
        bus.cfg_alm_full = 3'd2;
        bus.cfg_alm_empty = 3'd5;
        model_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        data_ctr = 10'd1;

        for (int i = 1; i <= 8; i++)  add(1, 0, 1, 0, i);
        for (int i = 1; i <= 8; i++)  add(0, 1, 0, 1, 8 - i);
        for (int i = 1; i <= 5; i++)  add(1, 0, 1, 0, i);
        for (int i = 0; i < 10; i++)  add(1, 1, 1, 1, 5);
        for (int i = 1; i <= 5; i++)  add(0, 1, 0, 1, 5 - i);
        for (int i = 1; i <= 8; i++)  add(1, 0, 1, 0, i);

        do_reset_init();

        foreach (tbl[i]) begin
            apply(tbl[i], data_ctr);
            if (tbl[i].push) data_ctr = data_ctr + 1'b1;
        end

        // Push while full with a simultaneous pop: only the pop proceeds.
        bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 10'h3FF;
        @(negedge clk);
        chk("full_we_a", bus.we_a, 1'b0);
        chk("full_re_a", bus.re_a, 1'b1);
        exp_q.push_back(model_q.pop_front());
        @(posedge clk); #1;
        chk("full_count", bus.fifo_count, 7);
        chk("full_flag", bus.full, 1'b0);
        chk("full_valid_out", bus.valid_out, 1'b1);
        chk("full_data_out", bus.data_out, exp_q.pop_front());
`ifdef FIFO_ERR_EN
        chk("err_state", bus.state, ST_ERROR);
        chk("err_flag", bus.error, 1'b1);
        @(negedge clk);
        chk("err_we_a", bus.we_a, 1'b0);
        chk("err_re_a", bus.re_a, 1'b0);
        @(posedge clk); #1;
        chk("err_state_hold", bus.state, ST_ERROR);
        chk("err_flag_hold", bus.error, 1'b1);
        chk("err_count_hold", bus.fifo_count, 7);
        bus.push = 1'b0; bus.pop = 1'b0;
`else
        chk("nerr_state", bus.state, ST_ACTIVE);
        bus.push = 1'b0; bus.pop = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            add(0, 1, 0, 1, 7 - i);
            apply(tbl[tbl.size() - 1], data_ctr);
        end
        // Pop while empty with a simultaneous push: only the push proceeds.
        add(1, 1, 1, 0, 1);
        apply(tbl[tbl.size() - 1], 10'h2A5);
        add(0, 1, 0, 1, 0);
        apply(tbl[tbl.size() - 1], data_ctr);
`endif

        // Reset asserted in the middle of a burst.
        do_reset_init();
        for (int i = 1; i <= 4; i++) begin
            v.push = 1; v.pop = 0; v.exp_we = 1; v.exp_re = 0; v.exp_cnt = i;
            apply(v, data_ctr);
            data_ctr = data_ctr + 1'b1;
        end
        reset = 1'b1; bus.push = 1'b1; bus.pop = 1'b1;
        @(negedge clk);
        chk("rstb_we_a", bus.we_a, 1'b0);
        chk("rstb_re_a", bus.re_a, 1'b0);
        @(posedge clk); #1;
        check_flags(0, ST_RESET);
        chk("rstb_valid_out", bus.valid_out, 1'b0);
        reset = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
        @(posedge clk); #1;
        chk("rstb_state_next", bus.state, ST_INIT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
